// File: rtl/pio_cmd_pkg.sv
// Shared command codes and sequencer state encoding for the HPS PIO command path.
package pio_cmd_pkg;

  localparam logic [5:0] CMD_WRITE_IMGRAM  = 6'h01;
  localparam logic [5:0] CMD_WRITE_REGCTRL = 6'h02;
  localparam logic [5:0] CMD_START_PROCESS = 6'h04;

  localparam int TIMEOUT_CNT_W = 26;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_PROC = 2'd2,
    ST_DONE_WAIT = 2'd3
  } seq_state_t;

endpackage

// File: rtl/pio_cmd_sequencer_rise_detect.sv
// Registered rising-edge detector; RESET_VAL sets what the previous level is assumed to be after reset.
module rise_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) sig_q <= RESET_VAL;
    else          sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/pio_cmd_sequencer.sv
// Turns the level-held HPS PIO enable into one single-cycle command strobe plus a four-phase done handshake.
// Optional build macro PIO_CMD_TIMEOUT_EN bounds the wait for processor completion.
module pio_cmd_sequencer
  import pio_cmd_pkg::*;
#(
  parameter int ADDR_W         = 15,
  parameter int DATA_W         = 32,
  parameter int CMD_W          = 6,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              hps_enable,
  input  logic [CMD_W-1:0]  hps_cmd,
  input  logic [ADDR_W-1:0] hps_address,
  input  logic [DATA_W-1:0] hps_data,
  input  logic              proc_done_in,
  output logic              img_wren,
  output logic [ADDR_W-1:0] img_addr,
  output logic [7:0]        img_data,
  output logic              reg_write,
  output logic [1:0]        reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              start_pulse,
  output logic              done_to_hps,
  output logic              busy,
  output logic              cmd_error,
  output logic              timeout_flag,
  output logic [15:0]       cmd_count
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << TIMEOUT_CNT_W)) begin : g_timeout_range_check
    $error("TIMEOUT_CYCLES out of range for the timeout counter");
  end

  seq_state_t        state;
  logic [CMD_W-1:0]  cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              en_rise;
  logic              pd_rise;

  // Enable starts "high" after reset so a level held across reset release never fires.
  rise_detect #(.RESET_VAL(1'b1)) u_en_rise (
    .clk     (clk),
    .reset_n (reset_n),
    .sig     (hps_enable),
    .rise    (en_rise)
  );

  rise_detect #(.RESET_VAL(1'b0)) u_pd_rise (
    .clk     (clk),
    .reset_n (reset_n),
    .sig     (proc_done_in),
    .rise    (pd_rise)
  );

`ifdef PIO_CMD_TIMEOUT_EN
  localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_CNT_W-1:0] tmo_cnt;

  // Held at zero outside WAIT_PROC, so it is already cleared on entry.
  always_ff @(posedge clk) begin
    if (!reset_n)                  tmo_cnt <= '0;
    else if (state != ST_WAIT_PROC) tmo_cnt <= '0;
    else                           tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cmd_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      done_to_hps <= 1'b0;
      busy        <= 1'b0;
      cmd_error   <= 1'b0;
      cmd_count   <= '0;
`ifdef PIO_CMD_TIMEOUT_EN
      timeout_flag <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (en_rise) begin
            cmd_q     <= hps_cmd;
            addr_q    <= hps_address;
            data_q    <= hps_data;
            cmd_count <= cmd_count + 16'd1;
            busy      <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          case (cmd_q)
            CMD_START_PROCESS: state <= ST_WAIT_PROC;
            CMD_WRITE_IMGRAM,
            CMD_WRITE_REGCTRL: begin
              done_to_hps <= 1'b1;
              state       <= ST_DONE_WAIT;
            end
            default: begin
              cmd_error   <= 1'b1;
              done_to_hps <= 1'b1;
              state       <= ST_DONE_WAIT;
            end
          endcase
        end
        ST_WAIT_PROC: begin
          if (pd_rise) begin
            done_to_hps <= 1'b1;
            state       <= ST_DONE_WAIT;
          end
`ifdef PIO_CMD_TIMEOUT_EN
          else if (tmo_cnt == TIMEOUT_LAST) begin
            timeout_flag <= 1'b1;
            done_to_hps  <= 1'b1;
            state        <= ST_DONE_WAIT;
          end
`endif
        end
        ST_DONE_WAIT: begin
          if (!hps_enable) begin
            done_to_hps <= 1'b0;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Strobes decode straight from ISSUE so they line up with the fields latched one cycle earlier.
  assign img_wren    = (state == ST_ISSUE) && (cmd_q == CMD_WRITE_IMGRAM);
  assign reg_write   = (state == ST_ISSUE) && (cmd_q == CMD_WRITE_REGCTRL);
  assign start_pulse = (state == ST_ISSUE) && (cmd_q == CMD_START_PROCESS);

  assign img_addr  = addr_q;
  assign img_data  = data_q[7:0];
  assign reg_addr  = addr_q[1:0];
  assign reg_wdata = data_q;

endmodule

// File: tb/tb_pio_cmd_sequencer.sv
// Bench for pio_cmd_sequencer: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a transaction-level model. Honours PIO_CMD_TIMEOUT_EN like the design.
module tb_pio_cmd_sequencer;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;
  localparam int CMD_W  = 6;
  localparam int TMO    = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              hps_enable;
  logic [CMD_W-1:0]  hps_cmd;
  logic [ADDR_W-1:0] hps_address;
  logic [DATA_W-1:0] hps_data;
  logic              proc_done_in;
  logic              img_wren;
  logic [ADDR_W-1:0] img_addr;
  logic [7:0]        img_data;
  logic              reg_write;
  logic [1:0]        reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic              start_pulse;
  logic              done_to_hps;
  logic              busy;
  logic              cmd_error;
  logic              timeout_flag;
  logic [15:0]       cmd_count;

  pio_cmd_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CMD_W(CMD_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .hps_enable(hps_enable), .hps_cmd(hps_cmd),
    .hps_address(hps_address), .hps_data(hps_data), .proc_done_in(proc_done_in),
    .img_wren(img_wren), .img_addr(img_addr), .img_data(img_data),
    .reg_write(reg_write), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .start_pulse(start_pulse), .done_to_hps(done_to_hps), .busy(busy),
    .cmd_error(cmd_error), .timeout_flag(timeout_flag), .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 50)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Transaction-level model: one outstanding command, described by what phase of its life it is in.
  bit          m_valid = 1'b0;
  bit          m_en_prev, m_pd_prev;
  bit          m_active, m_fresh, m_waiting, m_done_ph;
  bit          m_en_edge, m_pd_edge;
  logic [5:0]  m_cmd;
  logic [14:0] m_addr;
  logic [31:0] m_data;
  logic [15:0] m_count;
  bit          m_err, m_tmo;
  int          m_wait_cycles;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_valid   = 1'b1;
      m_en_prev = 1'b1;
      m_pd_prev = 1'b0;
      m_active  = 1'b0; m_fresh = 1'b0; m_waiting = 1'b0; m_done_ph = 1'b0;
      m_cmd = '0; m_addr = '0; m_data = '0; m_count = '0;
      m_err = 1'b0; m_tmo = 1'b0; m_wait_cycles = 0;
    end else begin
      m_en_edge = hps_enable && !m_en_prev;
      m_pd_edge = proc_done_in && !m_pd_prev;
      if (!m_active) begin
        if (m_en_edge) begin
          m_active = 1'b1;
          m_fresh  = 1'b1;
          m_cmd    = hps_cmd;
          m_addr   = hps_address;
          m_data   = hps_data;
          m_count  = m_count + 16'd1;
        end
      end else if (m_fresh) begin
        m_fresh = 1'b0;
        if (m_cmd == 6'h04) begin
          m_waiting     = 1'b1;
          m_wait_cycles = 0;
        end else begin
          m_done_ph = 1'b1;
          if (m_cmd != 6'h01 && m_cmd != 6'h02) m_err = 1'b1;
        end
      end else if (m_waiting) begin
        m_wait_cycles++;
        if (m_pd_edge) begin
          m_waiting = 1'b0; m_done_ph = 1'b1;
        end
`ifdef PIO_CMD_TIMEOUT_EN
        else if (m_wait_cycles == TMO) begin
          m_waiting = 1'b0; m_done_ph = 1'b1; m_tmo = 1'b1;
        end
`endif
      end else if (m_done_ph && !hps_enable) begin
        m_done_ph = 1'b0;
        m_active  = 1'b0;
      end
      m_en_prev = hps_enable;
      m_pd_prev = proc_done_in;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("img_wren",     img_wren,     m_fresh && m_cmd == 6'h01);
      check("reg_write",    reg_write,    m_fresh && m_cmd == 6'h02);
      check("start_pulse",  start_pulse,  m_fresh && m_cmd == 6'h04);
      check("done_to_hps",  done_to_hps,  m_done_ph);
      check("busy",         busy,         m_active);
      check("cmd_error",    cmd_error,    m_err);
      check("timeout_flag", timeout_flag, m_tmo);
      check("cmd_count",    cmd_count,    m_count);
      check("img_addr",     img_addr,     m_addr);
      check("img_data",     img_data,     m_data[7:0]);
      check("reg_addr",     reg_addr,     m_addr[1:0]);
      check("reg_wdata",    reg_wdata,    m_data);
    end
  end

  initial begin
    reset_n = 1'b0; hps_enable = 1'b0; hps_cmd = '0;
    hps_address = '0; hps_data = '0; proc_done_in = 1'b0;

    // Image RAM write
    tick(2);
    reset_n = 1'b1;
    tick(1);
    @(negedge clk);
    check("t1_reset_count", cmd_count, 16'd0);
    check("t1_reset_busy",  busy, 1'b0);
    hps_cmd = 6'h01; hps_address = 15'h1234; hps_data = 32'h0000_00AB; hps_enable = 1'b1;
    tick(1);
    @(negedge clk);
    check("t1_img_wren", img_wren, 1'b1);
    check("t1_img_addr", img_addr, 15'h1234);
    check("t1_img_data", img_data, 8'hAB);
    check("t1_done_early", done_to_hps, 1'b0);
    tick(1);
    @(negedge clk);
    check("t1_img_wren_once", img_wren, 1'b0);
    check("t1_done", done_to_hps, 1'b1);
    check("t1_count", cmd_count, 16'd1);
    hps_enable = 1'b0;
    tick(1);
    @(negedge clk);
    check("t1_done_drop", done_to_hps, 1'b0);

    // Enable held across reset release
    reset_n = 1'b0; hps_enable = 1'b1; hps_cmd = 6'h02;
    hps_address = 15'd2; hps_data = 32'hDEAD_BEEF;
    tick(2);
    reset_n = 1'b1;
    tick(3);
    @(negedge clk);
    check("t2_no_trigger_busy", busy, 1'b0);
    check("t2_no_trigger_count", cmd_count, 16'd0);
    hps_enable = 1'b0;
    tick(1);
    hps_enable = 1'b1;
    tick(1);
    @(negedge clk);
    check("t2_reg_write", reg_write, 1'b1);
    check("t2_reg_wdata", reg_wdata, 32'hDEAD_BEEF);
    check("t2_reg_addr",  reg_addr, 2'd2);
    tick(1);
    hps_enable = 1'b0;
    tick(2);

    // Start with done already high; enable dropped early
    proc_done_in = 1'b1; hps_cmd = 6'h04; hps_enable = 1'b1;
    tick(1);
    @(negedge clk);
    check("t3_start_pulse", start_pulse, 1'b1);
    tick(1);
    @(negedge clk);
    check("t3_wait_done", done_to_hps, 1'b0);
    check("t3_wait_busy", busy, 1'b1);
    hps_enable = 1'b0;
    tick(5);
    @(negedge clk);
    check("t3_stale_done_ignored", done_to_hps, 1'b0);
    proc_done_in = 1'b0;
`ifdef PIO_CMD_TIMEOUT_EN
    tick(8);
`else
    tick(100);
`endif
    proc_done_in = 1'b1;
    tick(1);
    @(negedge clk);
    check("t3_done_after_rise", done_to_hps, 1'b1);
    tick(1);
    @(negedge clk);
    check("t3_done_one_cycle", done_to_hps, 1'b0);
    check("t3_idle", busy, 1'b0);

    // Unknown command, then a valid one
    hps_cmd = 6'h3F; hps_enable = 1'b1;
    tick(1);
    @(negedge clk);
    check("t4_no_strobe", {29'd0, img_wren, reg_write, start_pulse}, 32'd0);
    tick(1);
    @(negedge clk);
    check("t4_cmd_error", cmd_error, 1'b1);
    check("t4_done", done_to_hps, 1'b1);
    hps_enable = 1'b0;
    tick(1);
    hps_cmd = 6'h01; hps_enable = 1'b1;
    tick(1);
    @(negedge clk);
    check("t4_valid_after", img_wren, 1'b1);
    check("t4_error_sticky", cmd_error, 1'b1);
    tick(1);
    hps_enable = 1'b0;
    tick(1);

    // Reset while waiting on the processor
    proc_done_in = 1'b0; hps_cmd = 6'h04; hps_enable = 1'b1;
    tick(2);
    @(negedge clk);
    check("t5_in_wait", busy, 1'b1);
    reset_n = 1'b0;
    tick(1);
    @(negedge clk);
    check("t5_busy", busy, 1'b0);
    check("t5_done", done_to_hps, 1'b0);
    check("t5_count", cmd_count, 16'd0);
    reset_n = 1'b1; hps_enable = 1'b0;
    tick(2);
    proc_done_in = 1'b1;
    tick(2);
    @(negedge clk);
    check("t5_late_done_busy", busy, 1'b0);
    check("t5_late_done", done_to_hps, 1'b0);

    // Start with no processor completion
    proc_done_in = 1'b0;
    tick(1);
    hps_cmd = 6'h04; hps_enable = 1'b1;
    tick(2);
`ifdef PIO_CMD_TIMEOUT_EN
    for (int k = 1; k < TMO; k++) begin
      tick(1);
      @(negedge clk);
      check("t6_no_early_timeout", {30'd0, done_to_hps, timeout_flag}, 32'd0);
    end
    tick(1);
    @(negedge clk);
    check("t6_timeout_flag", timeout_flag, 1'b1);
    check("t6_timeout_done", done_to_hps, 1'b1);
    hps_enable = 1'b0;
    tick(1);
`else
    tick(200);
    @(negedge clk);
    check("t6_waits_forever", done_to_hps, 1'b0);
    check("t6_still_busy", busy, 1'b1);
    check("t6_no_timeout", timeout_flag, 1'b0);
    hps_enable = 1'b0;
`endif
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(1);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      int r;
      reset_n = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 3) == 0) hps_enable = ~hps_enable;
      r = $urandom_range(0, 9);
      if (r < 3)      hps_cmd = 6'h01;
      else if (r < 6) hps_cmd = 6'h02;
      else if (r < 8) hps_cmd = 6'h04;
      else            hps_cmd = 6'($urandom);
      hps_address = 15'($urandom);
      hps_data    = $urandom;
      if ($urandom_range(0, 5) == 0) proc_done_in = ~proc_done_in;
      tick(1);
    end

    reset_n = 1'b0;
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pio_cmd_sequencer.md
Name: pio_cmd_sequencer

Overview:
- Front-end stage between the HPS PIO command word and the command consumers: image RAM write port, register bank write port, and processing-start input of the main FSM.
- Turns the level-held HPS enable into exactly one single-cycle action per command.
- Latches address and data for that cycle.
- Runs a four-phase enable/done handshake back to the HPS. For start commands, done waits for the processor to finish.

Parameters:
- ADDR_W, 15, width of hps_address and img_addr.
- DATA_W, 32, width of hps_data and reg_wdata.
- CMD_W, 6, width of hps_cmd.
- TIMEOUT_CYCLES, 50000000, WAIT_PROC cycle limit. Used only with PIO_CMD_TIMEOUT_EN.

Ports:
- clk  in  1  system clock (50 MHz).
- reset_n  in  1  synchronous reset, active-low.
- hps_enable  in  1  command enable level from HPS.
- hps_cmd  in  CMD_W  command code: 0x01 image RAM write, 0x02 register write, 0x04 start processing.
- hps_address  in  ADDR_W  target address.
- hps_data  in  DATA_W  write data.
- proc_done_in  in  1  processor done level.
- img_wren  out  1  one-cycle image RAM write strobe.
- img_addr  out  ADDR_W  latched address.
- img_data  out  8  latched hps_data[7:0].
- reg_write  out  1  one-cycle register write strobe.
- reg_addr  out  2  latched hps_address[1:0].
- reg_wdata  out  DATA_W  latched hps_data.
- start_pulse  out  1  one-cycle processing start.
- done_to_hps  out  1  handshake done.
- busy  out  1  high in any state other than IDLE.
- cmd_error  out  1  sticky: unknown command seen.
- timeout_flag  out  1  sticky: processing timed out.
- cmd_count  out  16  accepted-command counter.

Behaviour:
- Reset (reset_n low at a clk edge):
  - State goes to IDLE.
  - All strobes, done_to_hps, busy, cmd_error, timeout_flag and cmd_count go to 0.
  - Latched fields go to 0.
  - en_q goes to 1, so an enable held high across reset release never triggers; the HPS must drop enable first.
  - Reset mid-operation aborts everything immediately, with no strobe emitted.
- Edge detect:
  - en_q registers hps_enable every cycle.
  - rise = hps_enable & ~en_q.
- IDLE:
  - On rise, latch cmd, address and data, increment cmd_count (wraps at 0xFFFF→0), and go to ISSUE.
  - A rise while not in IDLE is ignored; the edge is lost.
- ISSUE (exactly 1 cycle):
  - Decode the latched cmd and assert exactly one strobe.
  - Strobes are combinational from state==ISSUE plus the latched cmd; data is stable from the cycle before.
  - 0x01 → img_wren, then DONE_WAIT.
  - 0x02 → reg_write, then DONE_WAIT.
  - 0x04 → start_pulse, then WAIT_PROC.
  - Any other code → no strobe, cmd_error is set, then DONE_WAIT.
- WAIT_PROC:
  - pd_q registers proc_done_in.
  - Advance to DONE_WAIT on a rising proc_done_in (proc_done_in & ~pd_q).
  - A done level that was already high at entry does not count.
- DONE_WAIT:
  - done_to_hps = 1.
  - When hps_enable = 0, go to IDLE; done_to_hps is 0 from that next cycle.
- Latency, counting the rise edge as cycle 0:
  - Strobe in cycle 1.
  - For write commands, done_to_hps high from cycle 2.
- Deasserting enable before DONE_WAIT does not abort. The command completes; done pulses for 1 cycle, then the block returns to IDLE.

Optional Feature:
- Macro: PIO_CMD_TIMEOUT_EN.
- With the macro: a 26-bit counter runs in WAIT_PROC and clears on entry. When it reaches TIMEOUT_CYCLES-1 without a proc_done rise, timeout_flag is set (sticky until reset) and the state goes to DONE_WAIT.
- Without the macro: WAIT_PROC waits indefinitely, timeout_flag is tied to 0, and no counter logic is present.

Decomposition:
- Shared package pio_cmd_pkg holds:
  - CMD_WRITE_IMGRAM = 6'h01, CMD_WRITE_REGCTRL = 6'h02, CMD_START_PROCESS = 6'h04.
  - State encoding IDLE / ISSUE / WAIT_PROC / DONE_WAIT.
- One sub-module is natural: rise_detect, a registered edge detector with a reset value parameter. It is instantiated for hps_enable (reset 1) and proc_done_in (reset 0).

Test Plan:
1. Write to image RAM: release reset with enable=0, then cmd=0x01, addr=0x1234, data=0xAB, enable=1 held. Required: img_wren high for exactly 1 cycle, with img_addr=0x1234 and img_data=0xAB; done_to_hps high from the next cycle; after enable=0, done drops 1 cycle later; cmd_count=1.
2. Enable held across reset: enable=1 with cmd=0x02 during and after reset release. Required: no reg_write. Then enable 0→1 with data=0xDEADBEEF and addr=2. Required: a single reg_write with reg_wdata=0xDEADBEEF and reg_addr=2.
3. Start command: cmd=0x04 with proc_done_in already 1. Required: start_pulse once, and done_to_hps stays 0. Drop proc_done, then raise it 100 cycles later. Required: done_to_hps rises 1 cycle after the rise.
4. Unknown command: cmd=0x3F. Required: no strobe, cmd_error=1, done handshake completes; cmd_error stays 1 through the next valid command.
5. Reset mid-operation: reset_n low while in WAIT_PROC. Required: busy=0, done_to_hps=0, cmd_count=0 on the next cycle; the later proc_done rise is ignored.
6. Timeout (PIO_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16): start command with no done. Required: timeout_flag=1 and done_to_hps=1 exactly 16 cycles after entering WAIT_PROC. Without the macro, done never asserts.
